// File: rtl/noise_subtractor_pipe.sv
// Pipelined signal-minus-noise subtractor for the ANC datapath.
// The noise reference is aligned to the detector signal by a per-sample delay line.
// The result can be saturated or wrapped, and overflowed results are counted.
module noise_subtractor_pipe #(
   parameter int DATA_W    = 16,
   parameter int MAX_DELAY = 16,
   parameter int DLY_W     = $clog2(MAX_DELAY),
   parameter bit SAT_EN    = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DLY_W-1:0]  cfg_delay,
   input  logic              clr_count,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] sig_in,
   input  logic [DATA_W-1:0] ref_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] diff_out,
   output logic              sat_flag,
   output logic [CNT_W-1:0]  sat_count
);

   localparam logic [DLY_W:0]    DEPTH   = (DLY_W+1)'(MAX_DELAY);
   localparam logic [DLY_W-1:0]  LAST_WP = DLY_W'(MAX_DELAY - 1);
   localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   logic [DATA_W-1:0] dly_mem [MAX_DELAY];
   logic [DLY_W-1:0]  wp;
   logic [DLY_W:0]    fill;
   logic [DLY_W:0]    rd_sum;
   logic [DLY_W:0]    rd_wrapped;
   logic [DLY_W-1:0]  rd_addr;
   logic [DATA_W-1:0] ref_delayed;

   logic              advance;
   logic              accept;
   logic              transfer;

   logic              v1;
   logic [DATA_W-1:0] sig1;
   logic [DATA_W-1:0] ref1;
   logic              v2;

   logic [DATA_W:0]   full;
   logic              ovf;
   logic [DATA_W-1:0] diff_next;

   // The whole pipeline moves together: it advances whenever the output slot is free or draining.
   always_comb begin
      advance   = ~v2 | out_ready;
      in_ready  = rst_n & advance;
      accept    = in_valid & in_ready;
      transfer  = v2 & out_ready;
      out_valid = v2;
   end

   // Pick the reference sample d accepts back; zero until enough samples have been seen, bypass for d=0.
   always_comb begin
      rd_sum     = {1'b0, wp} + DEPTH - {1'b0, cfg_delay};
      rd_wrapped = rd_sum - DEPTH;
      rd_addr    = rd_sum[DLY_W-1:0];
      if (rd_sum >= DEPTH) begin
         rd_addr = rd_wrapped[DLY_W-1:0];
      end
      ref_delayed = '0;
      if (cfg_delay == '0) begin
         ref_delayed = ref_in;
      end else if (fill >= {1'b0, cfg_delay}) begin
         ref_delayed = dly_mem[rd_addr];
      end
   end

   // Delay-line storage is written once per accepted sample and never cleared.
   always_ff @(posedge clk) begin
      if (accept) begin
         dly_mem[wp] <= ref_in;
      end
   end

   // Write pointer wraps around the buffer; fill tracks how much history exists for priming.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp   <= '0;
         fill <= '0;
      end else if (accept) begin
         wp <= (wp == LAST_WP) ? '0 : wp + DLY_W'(1);
         if (fill != DEPTH) begin
            fill <= fill + (DLY_W+1)'(1);
         end
      end
   end

   // Stage 1 captures the signal and its aligned reference.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         sig1 <= '0;
         ref1 <= '0;
      end else if (advance) begin
         v1   <= accept;
         sig1 <= sig_in;
         ref1 <= ref_delayed;
      end
   end

   // One extra bit of headroom exposes overflow; clamp toward the overflow direction when saturating.
   always_comb begin
      full      = {sig1[DATA_W-1], sig1} - {ref1[DATA_W-1], ref1};
      ovf       = full[DATA_W] ^ full[DATA_W-1];
      diff_next = full[DATA_W-1:0];
      if (SAT_EN && ovf) begin
         diff_next = full[DATA_W] ? NEG_MIN : POS_MAX;
      end
   end

   // Stage 2 holds the result; it stays frozen while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2       <= 1'b0;
         diff_out <= '0;
         sat_flag <= 1'b0;
      end else if (advance) begin
         v2       <= v1;
         diff_out <= diff_next;
         sat_flag <= ovf;
      end
   end

   // Count overflowed results as they leave; clear wins, and the count sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count <= '0;
      end else if (clr_count) begin
         sat_count <= '0;
      end else if (transfer && sat_flag && !(&sat_count)) begin
         sat_count <= sat_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_noise_subtractor_pipe.sv
// Self-checking bench for noise_subtractor_pipe: saturating, wrapping and 4-bit-counter builds
// share one stimulus stream and are compared against a sample-level reference model.
module tb_noise_subtractor_pipe;

   logic        clk;
   logic        rst_n;
   logic [3:0]  cfg_delay;
   logic        clr_count;
   logic        in_valid;
   logic [15:0] sig_in;
   logic [15:0] ref_in;
   logic        out_ready;

   logic        in_ready,  out_valid,  sat_flag;
   logic [15:0] diff_out,  sat_count;
   logic        in_ready_w, out_valid_w, sat_flag_w;
   logic [15:0] diff_out_w, sat_count_w;
   logic        in_ready_c, out_valid_c, sat_flag_c;
   logic [15:0] diff_out_c;
   logic [3:0]  sat_count_c;

   noise_subtractor_pipe dut (
      .clk(clk), .rst_n(rst_n), .cfg_delay(cfg_delay), .clr_count(clr_count),
      .in_valid(in_valid), .in_ready(in_ready), .sig_in(sig_in), .ref_in(ref_in),
      .out_valid(out_valid), .out_ready(out_ready), .diff_out(diff_out),
      .sat_flag(sat_flag), .sat_count(sat_count)
   );

   noise_subtractor_pipe #(.SAT_EN(1'b0)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .cfg_delay(cfg_delay), .clr_count(clr_count),
      .in_valid(in_valid), .in_ready(in_ready_w), .sig_in(sig_in), .ref_in(ref_in),
      .out_valid(out_valid_w), .out_ready(out_ready), .diff_out(diff_out_w),
      .sat_flag(sat_flag_w), .sat_count(sat_count_w)
   );

   noise_subtractor_pipe #(.CNT_W(4)) dut_c4 (
      .clk(clk), .rst_n(rst_n), .cfg_delay(cfg_delay), .clr_count(clr_count),
      .in_valid(in_valid), .in_ready(in_ready_c), .sig_in(sig_in), .ref_in(ref_in),
      .out_valid(out_valid_c), .out_ready(out_ready), .diff_out(diff_out_c),
      .sat_flag(sat_flag_c), .sat_count(sat_count_c)
   );

   typedef struct {
      logic [15:0] dsat;
      logic [15:0] dwrap;
      logic        flag;
   } exp_t;

   exp_t        expq[$];
   logic [15:0] hist[$];
   logic [15:0] got[$];
   logic [15:0] got_w[$];
   int          cnt16;
   int          cnt4;
   int          total;
   int          passed;
   int          failed;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t refModel(input logic [15:0] s, input logic [15:0] r);
      exp_t e;
      int   full;
      full    = int'($signed(s)) - int'($signed(r));
      e.flag  = (full > 32767) || (full < -32768);
      e.dwrap = 16'(full);
      if (full > 32767)       e.dsat = 16'h7FFF;
      else if (full < -32768) e.dsat = 16'h8000;
      else                    e.dsat = 16'(full);
      return e;
   endfunction

   task automatic applyStimulus(input logic iv, input logic [15:0] s, input logic [15:0] r,
                                input logic ordy, input logic clr, output logic acc);
      logic        xfer;
      int          d;
      int          n;
      logic [15:0] rd;
      exp_t        e;
      in_valid  = iv;
      sig_in    = s;
      ref_in    = r;
      out_ready = ordy;
      clr_count = clr;
      #1;
      acc  = in_valid & in_ready;
      xfer = out_valid & out_ready;
      if (out_valid && !out_ready) checkOutput("in_ready_stall", in_ready, 0);
      if (out_valid) begin
         if (expq.size() == 0) begin
            checkOutput("unexpected_out_valid", out_valid, 0);
         end else begin
            checkOutput("diff_sat",  diff_out,   expq[0].dsat);
            checkOutput("flag_sat",  sat_flag,   expq[0].flag);
            checkOutput("diff_wrap", diff_out_w, expq[0].dwrap);
            checkOutput("flag_wrap", sat_flag_w, expq[0].flag);
         end
      end
      if (xfer) begin
         got.push_back(diff_out);
         got_w.push_back(diff_out_w);
      end
      if (acc) begin
         d  = int'(cfg_delay);
         n  = hist.size();
         rd = 16'h0;
         if (d == 0)      rd = r;
         else if (n >= d) rd = hist[n-d];
         hist.push_back(r);
         expq.push_back(refModel(s, rd));
      end
      @(posedge clk);
      e.flag = 1'b0;
      if (xfer && expq.size() > 0) e = expq.pop_front();
      if (clr) begin
         cnt16 = 0;
         cnt4  = 0;
      end else if (xfer && e.flag) begin
         if (cnt16 < 65535) cnt16++;
         if (cnt4 < 15)     cnt4++;
      end
      @(negedge clk);
      checkOutput("sat_count",    sat_count,   cnt16);
      checkOutput("sat_count_c4", sat_count_c, cnt4);
   endtask

   task automatic drain();
      logic acc;
      for (int i = 0; i < 20 && expq.size() > 0; i++) applyStimulus(0, 0, 0, 1, 0, acc);
      checkOutput("drain_empty", expq.size(), 0);
      applyStimulus(0, 0, 0, 1, 0, acc);
      checkOutput("drain_no_extra", out_valid, 0);
   endtask

   task automatic doReset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_diff_out",  diff_out, 0);
      checkOutput("rst_sat_flag",  sat_flag, 0);
      checkOutput("rst_sat_count", sat_count, 0);
      checkOutput("rst_in_ready",  in_ready, 0);
      checkOutput("rst_count_c4",  sat_count_c, 0);
      expq.delete();
      hist.delete();
      got.delete();
      got_w.delete();
      cnt16 = 0;
      cnt4  = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic        acc;
      int          idx;
      int          t3_exp[5];
      logic [15:0] s4[8];
      logic [15:0] r4[8];
      logic [15:0] s5[3];
      total = 0; passed = 0; failed = 0; cnt16 = 0; cnt4 = 0;
      rst_n = 1'b0; cfg_delay = 4'd0; clr_count = 1'b0; in_valid = 1'b0;
      sig_in = '0; ref_in = '0; out_ready = 1'b1;
      t3_exp = '{100, 100, 100, 90, 80};
      @(negedge clk);
      @(negedge clk);
      doReset();

      // Basic subtraction and two-cycle latency
      cfg_delay = 4'd0;
      applyStimulus(1, 16'd1000, 16'd300, 1, 0, acc);
      checkOutput("t1_not_yet_valid", out_valid, 0);
      applyStimulus(0, 0, 0, 1, 0, acc);
      checkOutput("t1_valid", out_valid, 1);
      checkOutput("t1_diff",  diff_out, 700);
      checkOutput("t1_flag",  sat_flag, 0);
      drain();

      // Saturation at both ends, and wrap behaviour
      got.delete(); got_w.delete();
      applyStimulus(1, 16'h7FFF, 16'hFFFF, 1, 0, acc);
      applyStimulus(1, 16'h8000, 16'h0001, 1, 0, acc);
      drain();
      checkOutput("t2_count",     got.size(), 2);
      checkOutput("t2_pos_clamp", got[0], 16'h7FFF);
      checkOutput("t2_neg_clamp", got[1], 16'h8000);
      checkOutput("t2_pos_wrap",  got_w[0], 16'h8000);
      checkOutput("t2_satcount",  sat_count, 2);

      // Delay of three samples with priming, back-to-back then with idle gaps
      for (int pass = 0; pass < 2; pass++) begin
         doReset();
         cfg_delay = 4'd3;
         for (int i = 0; i < 5; i++) begin
            if (pass == 1) begin
               for (int k = 0; k < int'($urandom_range(3, 0)); k++) applyStimulus(0, 0, 0, 1, 0, acc);
            end
            applyStimulus(1, 16'd100, 16'(10 * (i + 1)), 1, 0, acc);
         end
         drain();
         checkOutput("t3_count", got.size(), 5);
         for (int i = 0; i < 5 && i < got.size(); i++) checkOutput("t3_diff", got[i], 16'(t3_exp[i]));
      end

      // Backpressure mid-stream
      cfg_delay = 4'($urandom_range(15, 0));
      for (int i = 0; i < 8; i++) begin
         s4[i] = 16'($urandom);
         r4[i] = 16'($urandom);
      end
      got.delete();
      idx = 0;
      for (int c = 0; c < 40 && idx < 8; c++) begin
         applyStimulus(1, s4[idx], r4[idx], !(c >= 3 && c < 8), 0, acc);
         if (acc) idx++;
      end
      checkOutput("t4_all_accepted", idx, 8);
      drain();
      checkOutput("t4_all_out", got.size(), 8);

      // Reset with samples in flight
      cfg_delay = 4'd0;
      applyStimulus(1, 16'h7FFF, 16'h8000, 1, 0, acc);
      drain();
      checkOutput("t5_pre_count_nonzero", (sat_count != 0), 1);
      cfg_delay = 4'd3;
      applyStimulus(1, 16'd5, 16'd7, 1, 0, acc);
      applyStimulus(1, 16'd6, 16'd8, 1, 0, acc);
      doReset();
      for (int i = 0; i < 3; i++) begin
         s5[i] = 16'($urandom_range(20000, 0));
         applyStimulus(1, s5[i], 16'($urandom_range(20000, 0)), 1, 0, acc);
      end
      drain();
      checkOutput("t5_count", got.size(), 3);
      for (int i = 0; i < 3 && i < got.size(); i++) checkOutput("t5_diff_eq_sig", got[i], s5[i]);

      // Random traffic with delay changes and occasional clears
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(9, 0) == 0) cfg_delay = 4'($urandom_range(15, 0));
         applyStimulus($urandom_range(3, 0) != 0,
                       ($urandom_range(3, 0) == 0) ? 16'h7FFF : 16'($urandom),
                       ($urandom_range(3, 0) == 0) ? 16'h8000 : 16'($urandom),
                       $urandom_range(2, 0) != 0, $urandom_range(19, 0) == 0, acc);
      end
      drain();

      // Counter saturation in the 4-bit build and clear priority
      doReset();
      cfg_delay = 4'd0;
      for (int i = 0; i < 20; i++) applyStimulus(1, 16'h7FFF, 16'hFFFF, 1, 0, acc);
      drain();
      checkOutput("t6_count_c4_sat", sat_count_c, 15);
      checkOutput("t6_count_16",     sat_count, 20);
      applyStimulus(1, 16'h7FFF, 16'hFFFF, 1, 0, acc);
      applyStimulus(0, 0, 0, 1, 0, acc);
      checkOutput("t6_ovf_pending", sat_flag, 1);
      applyStimulus(0, 0, 0, 1, 1, acc);
      checkOutput("t6_clr_16", sat_count, 0);
      checkOutput("t6_clr_c4", sat_count_c, 0);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
